bf_decoder: RTL and testbench



---
 rtl/kem_pkg.sv | 22 ++
 rtl/bf_upc_count.sv | 25 ++
 rtl/bf_decoder.sv | 160 ++++++++++++++++
 tb/tb_bf_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/kem_pkg.sv
// Shared defaults, FSM encoding and modular index helper for the bit-flipping decoder.
package kem_pkg;

  localparam int unsigned R_DEF     = 127;
  localparam int unsigned W_DEF     = 5;
  localparam int unsigned POS_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SCAN  = 2'd2
  } state_t;

  // (a + b) mod r for a < r and b < r: a single conditional subtract
  function automatic int unsigned mod_add_r(input int unsigned a, input int unsigned b,
                                            input int unsigned r);
    int unsigned sum;
    sum = a + b;
    return (sum >= r) ? sum - r : sum;
  endfunction

endpackage

// File: rtl/bf_upc_count.sv
// Unsatisfied-parity count: popcount of the W syndrome bits tapped at (j + pos[k]) mod R.
module bf_upc_count
  import kem_pkg::*;
#(
  parameter  int unsigned R     = R_DEF,
  parameter  int unsigned W     = W_DEF,
  parameter  int unsigned POS_W = POS_W_DEF,
  localparam int unsigned IDX_W = $clog2(R),
  localparam int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic [R-1:0]       s,
  input  logic [IDX_W-1:0]   j,
  input  logic [W*POS_W-1:0] pos,
  output logic [CNT_W-1:0]   upc
);

  // duplicate positions are counted once per occurrence
  always_comb begin
    upc = '0;
    for (int k = 0; k < W; k++) begin
      upc = upc + CNT_W'(s[IDX_W'(mod_add_r(32'(j), 32'(pos[k*POS_W +: POS_W]), R))]);
    end
  end

endmodule

// File: rtl/bf_decoder.sv
// Serial bit-flipping decoder for a two-block circulant code: one (block, bit) per SCAN cycle.
module bf_decoder
  import kem_pkg::*;
#(
  parameter  int unsigned R     = R_DEF,
  parameter  int unsigned W     = W_DEF,
  parameter  int unsigned POS_W = POS_W_DEF,
  parameter  int unsigned IT_W  = 4,
  localparam int unsigned IDX_W = $clog2(R),
  localparam int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [R-1:0]              s_in,
  input  logic [W*POS_W-1:0]        h0_pos_flat,
  input  logic [W*POS_W-1:0]        h1_pos_flat,
  input  logic [$clog2(W+1)-1:0]    threshold,
  input  logic [IT_W-1:0]           max_iter,
  output logic [R-1:0]              e0,
  output logic [R-1:0]              e1,
  output logic [R-1:0]              s_out,
  output logic [IT_W-1:0]           iter_cnt,
  output logic                      busy,
  output logic                      done,
  output logic                      success
);

  state_t             state_q, state_d;
  logic [W*POS_W-1:0] h0_q, h0_d, h1_q, h1_d, pos_sel;
  logic [CNT_W-1:0]   thr_q, thr_d, upc;
  logic [IT_W-1:0]    max_q, max_d, iter_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic               b_q, b_d;
  logic [R-1:0]       e0_d, e1_d, s_d, tap_mask;
  logic               busy_d, done_d, success_d;

  assign pos_sel = b_q ? h1_q : h0_q;

  bf_upc_count #(.R(R), .W(W), .POS_W(POS_W)) u_upc (
    .s   (s_out),
    .j   (j_q),
    .pos (pos_sel),
    .upc (upc)
  );

  // syndrome bits toggled by a flip; a repeated position toggles twice and cancels
  always_comb begin
    tap_mask = '0;
    for (int k = 0; k < W; k++) begin
      tap_mask[IDX_W'(mod_add_r(32'(j_q), 32'(pos_sel[k*POS_W +: POS_W]), R))] ^= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    h0_d      = h0_q;
    h1_d      = h1_q;
    thr_d     = thr_q;
    max_d     = max_q;
    j_d       = j_q;
    b_d       = b_q;
    e0_d      = e0;
    e1_d      = e1;
    s_d       = s_out;
    iter_d    = iter_cnt;
    busy_d    = busy;
    done_d    = 1'b0;
    success_d = success;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CHECK;
          s_d       = s_in;
          h0_d      = h0_pos_flat;
          h1_d      = h1_pos_flat;
          thr_d     = threshold;
          max_d     = max_iter;
          e0_d      = '0;
          e1_d      = '0;
          iter_d    = '0;
          j_d       = '0;
          b_d       = 1'b0;
          success_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      CHECK: begin
        if (s_out == '0) begin
          state_d   = IDLE;
          success_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end else if (iter_cnt == max_q) begin
          state_d   = IDLE;
          success_d = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end else begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (upc >= thr_q) begin
          if (b_q) e1_d[j_q] = ~e1[j_q];
          else     e0_d[j_q] = ~e0[j_q];
          s_d = s_out ^ tap_mask;
        end
        if (j_q == IDX_W'(R - 1)) begin
          j_d = '0;
          if (b_q) begin
            b_d     = 1'b0;
            iter_d  = iter_cnt + IT_W'(1);
            state_d = CHECK;
          end else begin
            b_d = 1'b1;
          end
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      h0_q     <= '0;
      h1_q     <= '0;
      thr_q    <= '0;
      max_q    <= '0;
      j_q      <= '0;
      b_q      <= 1'b0;
      e0       <= '0;
      e1       <= '0;
      s_out    <= '0;
      iter_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      success  <= 1'b0;
    end else begin
      state_q  <= state_d;
      h0_q     <= h0_d;
      h1_q     <= h1_d;
      thr_q    <= thr_d;
      max_q    <= max_d;
      j_q      <= j_d;
      b_q      <= b_d;
      e0       <= e0_d;
      e1       <= e1_d;
      s_out    <= s_d;
      iter_cnt <= iter_d;
      busy     <= busy_d;
      done     <= done_d;
      success  <= success_d;
    end
  end

endmodule

// File: tb/tb_bf_decoder.sv
// Directed scoreboard bench for bf_decoder with R=127, W=5.
module tb_bf_decoder;

  localparam int unsigned R = 127;
  localparam int unsigned W = 5;
  localparam int unsigned POS_W = 8;
  localparam int unsigned IT_W = 4;
  localparam logic [39:0] H0 = {8'd25, 8'd19, 8'd11, 8'd7, 8'd3};
  localparam logic [39:0] H1 = {8'd29, 8'd17, 8'd13, 8'd5, 8'd2};

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [R-1:0]   s_in;
  logic [39:0]    h0_pos_flat, h1_pos_flat;
  logic [2:0]     threshold;
  logic [3:0]     max_iter;
  logic [R-1:0]   e0, e1, s_out;
  logic [3:0]     iter_cnt;
  logic           busy, done, success;

  typedef struct {
    logic [R-1:0] e0;
    logic [R-1:0] e1;
    logic [R-1:0] s;
    logic [3:0]   it;
    logic         succ;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  bf_decoder #(.R(R), .W(W), .POS_W(POS_W), .IT_W(IT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .s_in        (s_in),
    .h0_pos_flat (h0_pos_flat),
    .h1_pos_flat (h1_pos_flat),
    .threshold   (threshold),
    .max_iter    (max_iter),
    .e0          (e0),
    .e1          (e1),
    .s_out       (s_out),
    .iter_cnt    (iter_cnt),
    .busy        (busy),
    .done        (done),
    .success     (success)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [R-1:0] bits5(input int a, b, c, d, e);
    logic [R-1:0] v;
    v = '0;
    v[7'(a)] = 1'b1; v[7'(b)] = 1'b1; v[7'(c)] = 1'b1; v[7'(d)] = 1'b1; v[7'(e)] = 1'b1;
    return v;
  endfunction

  // syndrome contribution of a single error at bit j of block b
  function automatic logic [R-1:0] col(input int b, input int j);
    logic [R-1:0] v;
    logic [39:0]  h;
    v = '0;
    h = (b == 1) ? H1 : H0;
    for (int k = 0; k < W; k++) v[7'((j + int'(h[k*8 +: 8])) % R)] ^= 1'b1;
    return v;
  endfunction

  // reference serial bit-flipping decoder
  function automatic exp_t model(input logic [R-1:0] s0, input logic [2:0] thr, input logic [3:0] mi);
    exp_t         r;
    logic [39:0]  h;
    int           upc, idx;
    r.s = s0; r.e0 = '0; r.e1 = '0; r.it = '0; r.succ = 1'b0; r.lat = 1;
    forever begin
      if (r.s == '0) begin r.succ = 1'b1; break; end
      if (r.it == mi) break;
      for (int b = 0; b < 2; b++) begin
        h = (b == 1) ? H1 : H0;
        for (int j = 0; j < int'(R); j++) begin
          upc = 0;
          for (int k = 0; k < W; k++) begin
            idx = (j + int'(h[k*8 +: 8])) % R;
            upc += int'(r.s[7'(idx)]);
          end
          if (upc >= int'(thr)) begin
            if (b == 1) r.e1[7'(j)] = ~r.e1[7'(j)];
            else        r.e0[7'(j)] = ~r.e0[7'(j)];
            for (int k = 0; k < W; k++) begin
              idx = (j + int'(h[k*8 +: 8])) % R;
              r.s[7'(idx)] = ~r.s[7'(idx)];
            end
          end
        end
      end
      r.it = r.it + 4'd1;
      r.lat += 2 * R + 1;
    end
    return r;
  endfunction

  // issue a start (accepted at the next edge), then wait for done and score it
  task automatic run(input string tag, input logic [R-1:0] s, input logic [2:0] thr,
                     input logic [3:0] mi, input exp_t ex, input int repulse);
    int   lat;
    bit   got;
    exp_t e;
    sb.push_back(ex);
    s_in = s; threshold = thr; max_iter = mi;
    h0_pos_flat = H0; h1_pos_flat = H1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy"}, 128'(busy), 128'(1'b1));
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(posedge clk); lat++; #1;
      start = 1'b0;
      if (lat == repulse) begin
        start = 1'b1;
        s_in  = '0;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk({tag, ".timeout"}, 128'(got), 128'(1'b1));
    if (got) begin
      e = sb.pop_front();
      chk({tag, ".latency"}, 128'(lat), 128'(e.lat));
      chk({tag, ".e0"}, 128'(e0), 128'(e.e0));
      chk({tag, ".e1"}, 128'(e1), 128'(e.e1));
      chk({tag, ".s_out"}, 128'(s_out), 128'(e.s));
      chk({tag, ".iter_cnt"}, 128'(iter_cnt), 128'(e.it));
      chk({tag, ".success"}, 128'(success), 128'(e.succ));
      chk({tag, ".busy_at_done"}, 128'(busy), 128'(1'b0));
    end else begin
      sb.delete();
    end
  endtask

  initial begin
    logic [R-1:0] s35, s_one, s2;
    exp_t         ex;
    rst_n = 1'b0; start = 1'b0; s_in = '0;
    h0_pos_flat = H0; h1_pos_flat = H1; threshold = 3'd3; max_iter = 4'd4;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.e0", 128'(e0), 128'(0));
    chk("rst.e1", 128'(e1), 128'(0));
    chk("rst.s_out", 128'(s_out), 128'(0));
    chk("rst.iter_cnt", 128'(iter_cnt), 128'(0));
    chk("rst.busy", 128'(busy), 128'(0));
    chk("rst.done", 128'(done), 128'(0));
    chk("rst.success", 128'(success), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    s35   = bits5(13, 17, 21, 29, 35);
    s_one = '0;
    s_one[0] = 1'b1;

    ex = '{e0: '0, e1: '0, s: '0, it: 4'd0, succ: 1'b1, lat: 1};
    run("zero_syn", '0, 3'd3, 4'd4, ex, -1);

    // started in the done cycle of the previous run
    ex = '{e0: '0, e1: '0, s: '0, it: 4'd1, succ: 1'b1, lat: 256};
    ex.e0[10] = 1'b1;
    run("one_err", s35, 3'd3, 4'd4, ex, -1);

    ex = '{e0: '0, e1: '0, s: s_one, it: 4'd0, succ: 1'b0, lat: 1};
    run("max_iter0", s_one, 3'd3, 4'd0, ex, -1);

    ex = '{e0: '0, e1: '0, s: s_one, it: 4'd2, succ: 1'b0, lat: 511};
    run("no_flip", s_one, 3'd5, 4'd2, ex, -1);
    @(posedge clk); #1;
    chk("no_flip.done_pulse", 128'(done), 128'(0));
    chk("no_flip.success_hold", 128'(success), 128'(0));
    chk("no_flip.s_hold", 128'(s_out), 128'(s_one));

    // reset mid-SCAN
    s_in = s35; threshold = 3'd3; max_iter = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.e0", 128'(e0), 128'(0));
    chk("abort.e1", 128'(e1), 128'(0));
    chk("abort.s_out", 128'(s_out), 128'(0));
    chk("abort.iter_cnt", 128'(iter_cnt), 128'(0));
    chk("abort.busy", 128'(busy), 128'(0));
    chk("abort.done", 128'(done), 128'(0));
    chk("abort.success", 128'(success), 128'(0));
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ex = '{e0: '0, e1: '0, s: '0, it: 4'd1, succ: 1'b1, lat: 256};
    ex.e0[10] = 1'b1;
    run("rerun", s35, 3'd3, 4'd4, ex, -1);

    run("repulse", s35, 3'd3, 4'd4, ex, 50);

    s2 = col(0, 40) ^ col(1, 90);
    ex = model(s2, 3'd3, 4'd4);
    run("two_err", s2, 3'd3, 4'd4, ex, -1);

    ex = model(s_one, 3'd0, 4'd1);
    run("thr0", s_one, 3'd0, 4'd1, ex, -1);
    chk("thr0.all_e0", 128'(e0), 128'({R{1'b1}}));
    chk("thr0.all_e1", 128'(e1), 128'({R{1'b1}}));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
